// File: rtl/axi4_lite_slave_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_regs_if
// Brief    : AXI4-Lite five-channel bundle with master/slave modports.
// Revision : 1.0
// ============================================================================
interface axi4_lite_slave_regs_if #(
    parameter int ADDRESS = 32
) ();
    logic [ADDRESS-1:0] S_AWADDR;
    logic               S_AWVALID;
    logic               S_AWREADY;
    logic [31:0]        S_WDATA;
    logic [3:0]         S_WSTRB;
    logic               S_WVALID;
    logic               S_WREADY;
    logic [1:0]         S_BRESP;
    logic               S_BVALID;
    logic               S_BREADY;
    logic [ADDRESS-1:0] S_ARADDR;
    logic               S_ARVALID;
    logic               S_ARREADY;
    logic [31:0]        S_RDATA;
    logic [1:0]         S_RRESP;
    logic               S_RVALID;
    logic               S_RREADY;

    modport master (
        output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
               S_ARADDR, S_ARVALID, S_RREADY,
        input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
               S_ARREADY, S_RDATA, S_RRESP, S_RVALID
    );

    modport slave (
        input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
               S_ARADDR, S_ARVALID, S_RREADY,
        output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
               S_ARREADY, S_RDATA, S_RRESP, S_RVALID
    );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_regs
// Brief    : AXI4-Lite slave register file, independent read/write FSMs.
//            Optional macro AXI4L_SLAVE_ERR_EN: out-of-range accesses answer
//            SLVERR instead of OKAY.
// Revision : 1.0
// ============================================================================
module axi4_lite_slave_regs #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  wire logic                           ACLK,
    input  wire logic                           ARESET,
    axi4_lite_slave_regs_if.slave               s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0]      REGS_OUT
);

    localparam int                 c_IDX_W      = $clog2(NUM_REGS);
    localparam logic [ADDRESS-1:0] c_ADDR_LIMIT = ADDRESS'(NUM_REGS * 4);
    localparam logic [1:0]         c_RESP_OKAY  = 2'b00;
`ifdef AXI4L_SLAVE_ERR_EN
    localparam logic [1:0]         c_RESP_OOR   = 2'b10;
`else
    localparam logic [1:0]         c_RESP_OOR   = 2'b00;
`endif

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];

    wstate_t                 r_wstate;
    logic                    r_awready;
    logic                    r_wready;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;
    logic                    r_aw_held;
    logic                    r_w_held;
    logic [ADDRESS-1:0]      r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [3:0]              r_wstrb;

    rstate_t                 r_rstate;
    logic                    r_arready;
    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_rresp;

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_aw_have;
    logic                    w_w_have;
    logic                    w_wr_commit;
    logic [ADDRESS-1:0]      w_wr_addr;
    logic [DATA_WIDTH-1:0]   w_wr_data;
    logic [3:0]              w_wr_strb;
    logic [c_IDX_W-1:0]      w_wr_idx;
    logic                    w_wr_inrange;
    logic                    w_ar_hs;
    logic [c_IDX_W-1:0]      w_rd_idx;
    logic                    w_rd_inrange;

    // A channel captured in an earlier cycle is taken from its holding
    // register; otherwise the live bus value is used, so a channel arriving
    // in the commit cycle itself needs no extra cycle.
    assign w_aw_hs      = r_awready & s_axi.S_AWVALID;
    assign w_w_hs       = r_wready  & s_axi.S_WVALID;
    assign w_aw_have    = r_aw_held | w_aw_hs;
    assign w_w_have     = r_w_held  | w_w_hs;
    assign w_wr_commit  = (r_wstate == W_IDLE) & w_aw_have & w_w_have;
    assign w_wr_addr    = r_aw_held ? r_awaddr : s_axi.S_AWADDR;
    assign w_wr_data    = r_w_held  ? r_wdata  : s_axi.S_WDATA;
    assign w_wr_strb    = r_w_held  ? r_wstrb  : s_axi.S_WSTRB;
    assign w_wr_idx     = w_wr_addr[2 +: c_IDX_W];
    assign w_wr_inrange = (w_wr_addr < c_ADDR_LIMIT);

    assign w_ar_hs      = r_arready & s_axi.S_ARVALID;
    assign w_rd_idx     = s_axi.S_ARADDR[2 +: c_IDX_W];
    assign w_rd_inrange = (s_axi.S_ARADDR < c_ADDR_LIMIT);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_wr_commit) begin
                        if (w_wr_inrange) begin
                            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                                if (w_wr_strb[b]) begin
                                    r_regs[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                                end
                            end
                        end
                        r_bresp   <= w_wr_inrange ? c_RESP_OKAY : c_RESP_OOR;
                        r_bvalid  <= 1'b1;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_wstate  <= W_RESP;
                    end else begin
                        if (w_aw_hs) begin
                            r_awaddr  <= s_axi.S_AWADDR;
                            r_aw_held <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_wdata  <= s_axi.S_WDATA;
                            r_wstrb  <= s_axi.S_WSTRB;
                            r_w_held <= 1'b1;
                        end
                        r_awready <= ~w_aw_have;
                        r_wready  <= ~w_w_have;
                    end
                end
                W_RESP: begin
                    if (s_axi.S_BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= 2'b00;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Register contents are sampled before this edge's write lands, so a
    // same-edge read sees the old value.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata   <= w_rd_inrange ? r_regs[w_rd_idx] : '0;
                        r_rresp   <= w_rd_inrange ? c_RESP_OKAY : c_RESP_OOR;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi.S_RREADY) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi.S_AWREADY = r_awready;
    assign s_axi.S_WREADY  = r_wready;
    assign s_axi.S_BVALID  = r_bvalid;
    assign s_axi.S_BRESP   = r_bresp;
    assign s_axi.S_ARREADY = r_arready;
    assign s_axi.S_RVALID  = r_rvalid;
    assign s_axi.S_RDATA   = r_rdata;
    assign s_axi.S_RRESP   = r_rresp;

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
            assign REGS_OUT[DATA_WIDTH*k +: DATA_WIDTH] = r_regs[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_slave_regs
// Brief    : Directed self-checking bench for axi4_lite_slave_regs.
// Revision : 1.0
// ============================================================================
module tb_axi4_lite_slave_regs;

`ifdef AXI4L_SLAVE_ERR_EN
    localparam logic [1:0] c_OOR = 2'b10;
`else
    localparam logic [1:0] c_OOR = 2'b00;
`endif

    logic         ACLK   = 1'b0;
    logic         ARESET = 1'b1;
    logic [511:0] regs_out;
    logic [31:0]  mdl [16];
    int           n_pass  = 0;
    int           n_total = 0;

    axi4_lite_slave_regs_if #(.ADDRESS(32)) bus ();

    axi4_lite_slave_regs #(
        .ADDRESS    (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (16)
    ) u_dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .s_axi    (bus),
        .REGS_OUT (regs_out)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [511:0] mdl_flat();
        logic [511:0] f;
        for (int k = 0; k < 16; k++) f[32*k +: 32] = mdl[k];
        return f;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
        int k;
        bus.S_AWADDR = a; bus.S_WDATA = d; bus.S_WSTRB = s;
        bus.S_AWVALID = 1'b1; bus.S_WVALID = 1'b1;
        k = 0;
        while (!(bus.S_AWREADY && bus.S_WREADY) && k < 20) begin tick(); k++; end
        if (k == 20) chk("wr_ready_timeout", 0, 1);
        tick();
        bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0;
        chk("wr_bvalid_latency", bus.S_BVALID, 1);
        resp = bus.S_BRESP;
        bus.S_BREADY = 1'b1;
        tick();
        bus.S_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int k;
        bus.S_ARADDR = a; bus.S_ARVALID = 1'b1;
        k = 0;
        while (!bus.S_ARREADY && k < 20) begin tick(); k++; end
        if (k == 20) chk("rd_ready_timeout", 0, 1);
        tick();
        bus.S_ARVALID = 1'b0;
        chk("rd_rvalid_latency", bus.S_RVALID, 1);
        d = bus.S_RDATA; resp = bus.S_RRESP;
        bus.S_RREADY = 1'b1;
        tick();
        bus.S_RREADY = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic        seen;

        bus.S_AWADDR = '0; bus.S_AWVALID = 1'b0; bus.S_WDATA = '0; bus.S_WSTRB = '0;
        bus.S_WVALID = 1'b0; bus.S_BREADY = 1'b0; bus.S_ARADDR = '0;
        bus.S_ARVALID = 1'b0; bus.S_RREADY = 1'b0;
        for (int k = 0; k < 16; k++) mdl[k] = 32'h0;

        // Reset state
        repeat (3) tick();
        chk("rst_readys", {bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY}, 3'b000);
        chk("rst_valids", {bus.S_BVALID, bus.S_RVALID, bus.S_BRESP, bus.S_RRESP, bus.S_RDATA}, 0);
        chk("rst_regs", regs_out, 0);
        ARESET = 1'b0;
        tick();
        chk("post_rst_readys", {bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY}, 3'b111);

        // Simultaneous AW/W with BREADY already high
        bus.S_AWADDR = 32'h08; bus.S_WDATA = 32'hDEADBEEF; bus.S_WSTRB = 4'hF;
        bus.S_AWVALID = 1'b1; bus.S_WVALID = 1'b1; bus.S_BREADY = 1'b1;
        tick();
        mdl[2] = 32'hDEADBEEF;
        chk("t1_bvalid_bresp", {bus.S_BVALID, bus.S_BRESP}, 3'b100);
        chk("t1_regs", regs_out, mdl_flat());
        bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0;
        tick();
        chk("t1_b_done", {bus.S_BVALID, bus.S_AWREADY, bus.S_WREADY}, 3'b011);
        bus.S_BREADY = 1'b0;
        do_read(32'h08, d, r);
        chk("t1_rdata", d, 32'hDEADBEEF);
        chk("t1_rresp", r, 2'b00);

        // W first, AW three cycles later
        bus.S_WDATA = 32'h12345678; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1'b1;
        tick();
        bus.S_WVALID = 1'b0;
        chk("t2_w_captured", {bus.S_WREADY, bus.S_AWREADY, bus.S_BVALID}, 3'b010);
        tick(); tick();
        chk("t2_no_early_commit", {bus.S_BVALID, regs_out}, {1'b0, mdl_flat()});
        bus.S_AWADDR = 32'h04; bus.S_AWVALID = 1'b1;
        tick();
        bus.S_AWVALID = 1'b0;
        mdl[1] = 32'h12345678;
        chk("t2_commit", {bus.S_BVALID, regs_out}, {1'b1, mdl_flat()});
        bus.S_BREADY = 1'b1; tick(); bus.S_BREADY = 1'b0;

        // Byte strobes
        do_write(32'h0C, 32'hFFFFFFFF, 4'hF, r);
        do_write(32'h0C, 32'h00000000, 4'b0101, r);
        mdl[3] = 32'hFF00FF00;
        do_read(32'h0C, d, r);
        chk("t3_strobe_rdata", d, 32'hFF00FF00);
        do_write(32'h0C, 32'h00000000, 4'b0000, r);
        chk("t3_nostrobe_bresp", r, 2'b00);
        chk("t3_nostrobe_regs", regs_out, mdl_flat());

        // Read stalled by RREADY low
        do_write(32'h10, 32'hA5A50F0F, 4'hF, r);
        mdl[4] = 32'hA5A50F0F;
        bus.S_ARADDR = 32'h10; bus.S_ARVALID = 1'b1;
        tick();
        bus.S_ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_hold", {bus.S_RVALID, bus.S_ARREADY, bus.S_RDATA}, {2'b10, 32'hA5A50F0F});
            tick();
        end
        bus.S_RREADY = 1'b1;
        tick();
        bus.S_RREADY = 1'b0;
        chk("t4_r_done", {bus.S_RVALID, bus.S_ARREADY}, 2'b01);

        // Same-edge read and write of one register
        do_write(32'h14, 32'h1, 4'hF, r);
        mdl[5] = 32'h1;
        bus.S_AWADDR = 32'h14; bus.S_WDATA = 32'h2; bus.S_WSTRB = 4'hF;
        bus.S_ARADDR = 32'h14;
        bus.S_AWVALID = 1'b1; bus.S_WVALID = 1'b1; bus.S_ARVALID = 1'b1;
        tick();
        bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0; bus.S_ARVALID = 1'b0;
        mdl[5] = 32'h2;
        chk("t5_read_old", {bus.S_RVALID, bus.S_RDATA}, {1'b1, 32'h1});
        chk("t5_write_new", {bus.S_BVALID, regs_out}, {1'b1, mdl_flat()});
        bus.S_BREADY = 1'b1; bus.S_RREADY = 1'b1;
        tick();
        bus.S_BREADY = 1'b0; bus.S_RREADY = 1'b0;
        do_read(32'h14, d, r);
        chk("t5_read_new", d, 32'h2);

        // Range boundary: last register and first out-of-range address
        do_write(32'h00, 32'h11111111, 4'hF, r);
        mdl[0] = 32'h11111111;
        do_write(32'h3C, 32'hCAFEF00D, 4'hF, r);
        mdl[15] = 32'hCAFEF00D;
        chk("t6_last_reg_bresp", r, 2'b00);
        do_read(32'h3C, d, r);
        chk("t6_last_reg_rdata", d, 32'hCAFEF00D);
        do_write(32'h40, 32'hBAD0BAD0, 4'hF, r);
        chk("t6_oor_bresp", r, c_OOR);
        chk("t6_oor_regs", regs_out, mdl_flat());
        do_read(32'h40, d, r);
        chk("t6_oor_rdata", d, 32'h0);
        chk("t6_oor_rresp", r, c_OOR);

        // Reset while B and R responses are pending
        bus.S_AWADDR = 32'h18; bus.S_WDATA = 32'h77; bus.S_WSTRB = 4'hF;
        bus.S_ARADDR = 32'h08;
        bus.S_AWVALID = 1'b1; bus.S_WVALID = 1'b1; bus.S_ARVALID = 1'b1;
        tick();
        bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0; bus.S_ARVALID = 1'b0;
        chk("t7_pending", {bus.S_BVALID, bus.S_RVALID, bus.S_RDATA}, {2'b11, 32'hDEADBEEF});
        #2;
        ARESET = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) mdl[k] = 32'h0;
        chk("t7_rst_outputs", {bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID, bus.S_BRESP,
                                bus.S_ARREADY, bus.S_RVALID, bus.S_RRESP, bus.S_RDATA}, 0);
        chk("t7_rst_regs", regs_out, mdl_flat());
        bus.S_BREADY = 1'b1; bus.S_RREADY = 1'b1;
        tick(); tick();
        ARESET = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (bus.S_BVALID || bus.S_RVALID) seen = 1'b1;
        end
        chk("t7_no_stale_resp", seen, 1'b0);
        chk("t7_readys_back", {bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY}, 3'b111);
        bus.S_BREADY = 1'b0; bus.S_RREADY = 1'b0;
        do_read(32'h08, d, r);
        chk("t7_reg_cleared", d, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
